// File: rtl/axi_arb_requester.sv
// Arbitrated burst requester: queues burst commands, requests a shared bus from an
// arbiter, streams beats through once granted, and acknowledges each finished burst.
module axi_arb_requester #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int CMD_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [LEN_WIDTH-1:0]         cmd_len,
  output logic [$clog2(CMD_DEPTH):0]   cmd_count,
  output logic                         request,
  input  logic                         grant,
  output logic                         acknowledge,
  input  logic [DATA_WIDTH-1:0]        s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic                         grant_lost,
  output logic                         busy
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t               r_state;
  logic [LEN_WIDTH-1:0] r_mem [CMD_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_beat_cnt;
  logic                 r_request;
  logic                 r_ack;
  logic                 r_grant_lost;

  logic w_push;
  logic w_pop;
  logic w_xfer;
  logic w_fire;
  logic w_last;

  assign cmd_ready = (r_count < CNT_W'(CMD_DEPTH));
  assign w_push    = cmd_valid && cmd_ready;
  // The head is only consumed on the IDLE -> REQ transition.
  assign w_pop     = (r_state == IDLE) && (r_count != '0);

  assign w_xfer = (r_state == XFER);
  assign w_last = w_xfer && (r_beat_cnt == r_len);
  assign w_fire = m_valid && m_ready;

  assign m_valid     = w_xfer && s_valid && grant;
  assign s_ready     = w_xfer && m_ready && grant;
  assign m_data      = s_data;
  assign m_last      = w_last;
  assign request     = r_request;
  assign acknowledge = r_ack;
  assign grant_lost  = r_grant_lost;
  assign busy        = (r_state != IDLE);
  assign cmd_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= cmd_len;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_beat_cnt   <= '0;
      r_request    <= 1'b0;
      r_ack        <= 1'b0;
      r_grant_lost <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_count != '0) begin
            r_state    <= REQ;
            r_len      <= r_mem[r_rd_ptr];
            r_beat_cnt <= '0;
            r_request  <= 1'b1;
          end
        end
        REQ: begin
          if (grant) begin
            r_state <= XFER;
          end
        end
        XFER: begin
          // Losing grant mid-burst only stalls the stream; the flag records it.
          if (!grant) begin
            r_grant_lost <= 1'b1;
          end
          if (w_fire) begin
            if (w_last) begin
              r_state   <= ACK;
              r_request <= 1'b0;
              r_ack     <= 1'b1;
            end else begin
              r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
            end
          end
        end
        ACK: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
